// File: rtl/dct_seq_pkg.sv
// dct_seq_pkg: state encoding and block-size helpers shared by the transform sequencer
package dct_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLR, RD, MAC, RESULT} state_e;
  localparam int DEF_LOG2N = 3;
  function automatic int n_of(input int log2n);
    return 1 << log2n;
  endfunction
  function automatic int aw_of(input int log2n);
    return 2 * log2n;
  endfunction
endpackage

// File: rtl/dct_idx_cnt.sv
// dct_idx_cnt: 2-D wrap counter, col steps fastest and row advances on col wrap
module dct_idx_cnt #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [LOG2N-1:0] row,
  output logic [LOG2N-1:0] col,
  output logic             last
);
  logic [LOG2N-1:0] row_q, row_d, col_q, col_d;
  always_comb begin
    col_d = clr ? '0 : inc ? col_q + 1'b1 : col_q;
    row_d = clr ? '0 : (inc && &col_q) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  assign row  = row_q;
  assign col  = col_q;
  assign last = &{row_q, col_q};
endmodule

// File: rtl/dct_seq_ctrl.sv
// dct_seq_ctrl: walks every (u,v) sample for each (x,y) coefficient, driving sample reads and the MAC.
// Defining DCT_SEQ_STALL_CNT_EN adds stall_cnt, a saturating count of held RD/MAC cycles.
module dct_seq_ctrl
  import dct_seq_pkg::*;
#(
  parameter  int LOG2N = DEF_LOG2N,
  localparam int AW    = aw_of(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             acc_clr,
  output logic             rd_en,
  output logic             act_mac,
  output logic [AW-1:0]    address,
  output logic [LOG2N-1:0] u,
  output logic [LOG2N-1:0] v,
  output logic [LOG2N-1:0] x,
  output logic [LOG2N-1:0] y,
`ifdef DCT_SEQ_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             out_valid
);
  state_e state_q, state_d;
  logic busy_q, done_q, acc_clr_q, rd_en_q, act_mac_q, out_valid_q;
  logic busy_d, done_d, acc_clr_d, rd_en_d, act_mac_d, out_valid_d;
  logic uv_last, xy_last;
  dct_idx_cnt #(.LOG2N(LOG2N)) u_uv (
    .clk(clk), .rst(rst_in),
    .clr(state_d == IDLE || state_d == CLR),
    .inc(state_q == MAC && !hold),
    .row(u), .col(v), .last(uv_last)
  );
  dct_idx_cnt #(.LOG2N(LOG2N)) u_xy (
    .clk(clk), .rst(rst_in),
    .clr(state_d == IDLE),
    .inc(state_q == RESULT && out_ready),
    .row(y), .col(x), .last(xy_last)
  );
  always_comb
    state_d = abort                ? IDLE :
              state_q == IDLE      ? (start ? CLR : IDLE) :
              state_q == CLR       ? RD :
              state_q == RD        ? (hold ? RD : MAC) :
              state_q == MAC       ? (hold ? MAC : uv_last ? RESULT : RD) :
              state_q == RESULT    ? (!out_ready ? RESULT : xy_last ? IDLE : CLR) :
                                     IDLE;
  // act_mac fires only on the RD->MAC step, so a held MAC never accumulates twice
  always_comb begin
    busy_d      = state_d != IDLE;
    acc_clr_d   = state_d == CLR;
    rd_en_d     = state_d == RD || state_d == MAC;
    act_mac_d   = state_d == MAC && state_q == RD;
    out_valid_d = state_d == RESULT;
    done_d      = !abort && state_q == RESULT && out_ready && xy_last;
  end
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      act_mac_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      acc_clr_q   <= acc_clr_d;
      rd_en_q     <= rd_en_d;
      act_mac_q   <= act_mac_d;
      out_valid_q <= out_valid_d;
    end
  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_clr   = acc_clr_q;
  assign rd_en     = rd_en_q;
  assign act_mac   = act_mac_q;
  assign out_valid = out_valid_q;
  assign address   = {u, v};
`ifdef DCT_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == IDLE && start && !abort) ? '0 :
              (hold && (state_q == RD || state_q == MAC) && ~&stall_q) ? stall_q + 16'd1 :
              stall_q;
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_dct_seq_ctrl.sv
// tb_dct_seq_ctrl: scoreboard bench for the sequencer at N=8 (main) and N=2 (address walk)
module tb_dct_seq_ctrl;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic start = 1'b0, hold = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic busy, done, acc_clr, rd_en, act_mac, out_valid;
  logic [5:0] address;
  logic [2:0] u, v, x, y;
  logic b_start = 1'b0;
  logic b_busy, b_done, b_acc_clr, b_rd_en, b_act_mac, b_out_valid;
  logic [1:0] b_address;
  logic [0:0] b_u, b_v, b_x, b_y;
`ifdef DCT_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt, b_stall_cnt;
`endif
  logic [5:0] exp_q[$];
  logic [1:0] exp_a[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dct_seq_ctrl #(.LOG2N(3)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .hold(hold), .abort(abort),
    .out_ready(out_ready), .busy(busy), .done(done), .acc_clr(acc_clr),
    .rd_en(rd_en), .act_mac(act_mac), .address(address),
    .u(u), .v(v), .x(x), .y(y),
`ifdef DCT_SEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_valid(out_valid)
  );

  dct_seq_ctrl #(.LOG2N(1)) dut_b (
    .clk(clk), .rst_in(rst_in), .start(b_start), .hold(1'b0), .abort(1'b0),
    .out_ready(1'b1), .busy(b_busy), .done(b_done), .acc_clr(b_acc_clr),
    .rd_en(b_rd_en), .act_mac(b_act_mac), .address(b_address),
    .u(b_u), .v(b_v), .x(b_x), .y(b_y),
`ifdef DCT_SEQ_STALL_CNT_EN
    .stall_cnt(b_stall_cnt),
`endif
    .out_valid(b_out_valid)
  );

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, acc_clr, rd_en, act_mac, out_valid} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, acc_clr, rd_en, act_mac, out_valid});
    end
    tests++;
    if ({address, u, v, x, y} !== 18'b0) begin
      fails++; $display("FAIL reset_idx got %h want 0", {address, u, v, x, y});
    end
    tests++;
    if ({b_busy, b_done, b_acc_clr, b_rd_en, b_act_mac, b_out_valid, b_address, b_u, b_v, b_x, b_y} !== 12'b0) begin
      fails++; $display("FAIL reset_small got %h want 0",
        {b_busy, b_done, b_acc_clr, b_rd_en, b_act_mac, b_out_valid, b_address, b_u, b_v, b_x, b_y});
    end
`ifdef DCT_SEQ_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
  endtask

  task automatic test_full_block;
    int first = -1;
    int nbusy = 0;
    int ncoef = 0;
    int ndone = 0;
    logic [5:0] e;
    exp_q.delete();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++) exp_q.push_back(6'(yy * 8 + xx));
    out_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 8400; c++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (out_valid) begin
        if (first < 0) first = c;
        ncoef++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL full_coef_extra got (%0d,%0d) want none", x, y);
        end else begin
          e = exp_q.pop_front();
          if ({y, x} !== e) begin
            fails++; $display("FAIL full_coef_order got (%0d,%0d) want (%0d,%0d)", x, y, e[2:0], e[5:3]);
          end
        end
      end
      @(negedge clk);
    end
    tests++;
    if (first != 130) begin fails++; $display("FAIL full_first_valid got %0d want 130", first); end
    tests++;
    if (nbusy != 8320) begin fails++; $display("FAIL full_busy_cycles got %0d want 8320", nbusy); end
    tests++;
    if (ncoef != 64) begin fails++; $display("FAIL full_coef_count got %0d want 64", ncoef); end
    tests++;
    if (ndone != 1) begin fails++; $display("FAIL full_done_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_small;
    int nclr = 0;
    int nmac = 0;
    int ncoef = 0;
    int ndone = 0;
    logic [1:0] e;
    exp_a.delete();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 4; a++) exp_a.push_back(2'(a));
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (b_acc_clr) begin
        if (nclr > 0) begin
          tests++;
          if (nmac != 4) begin fails++; $display("FAIL small_mac_per_clr got %0d want 4", nmac); end
        end
        nclr++;
        nmac = 0;
      end
      if (b_act_mac) nmac++;
      if (b_rd_en && !b_act_mac) begin
        tests++;
        if (exp_a.size() == 0) begin
          fails++; $display("FAIL small_addr_extra got %0d want none", b_address);
        end else begin
          e = exp_a.pop_front();
          if (b_address !== e) begin fails++; $display("FAIL small_addr got %0d want %0d", b_address, e); end
        end
      end
      if (b_out_valid) ncoef++;
      if (b_done) ndone++;
      @(negedge clk);
    end
    tests++;
    if (nmac != 4) begin fails++; $display("FAIL small_mac_last got %0d want 4", nmac); end
    tests++;
    if (ncoef != 4 || nclr != 4) begin fails++; $display("FAIL small_coefs got %0d/%0d want 4/4", ncoef, nclr); end
    tests++;
    if (ndone != 1) begin fails++; $display("FAIL small_done got %0d want 1", ndone); end
    tests++;
    if (exp_a.size() != 0) begin fails++; $display("FAIL small_addr_missing got %0d left want 0", exp_a.size()); end
  endtask

  task automatic test_hold;
    int c = 1;
    int first = -1;
    int nmac = 0;
    int hcnt = 0;
    bit injected = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    while (c < 400 && first < 0) begin
      if (hcnt > 0) begin
        tests++;
        if ({act_mac, rd_en, u, v} !== {1'b0, 1'b1, 3'd2, 3'd5}) begin
          fails++; $display("FAIL hold_freeze got act_mac=%b rd_en=%b u=%0d v=%0d want 0 1 2 5", act_mac, rd_en, u, v);
        end
        hcnt--;
        if (hcnt == 0) hold = 1'b0;
      end else if (act_mac && u == 3'd2 && v == 3'd5 && !injected) begin
        hold = 1'b1;
        hcnt = 5;
        injected = 1'b1;
      end
      if (act_mac) nmac++;
      if (out_valid) first = c;
      if (first < 0) begin
        @(negedge clk);
        c++;
      end
    end
    tests++;
    if (first != 135) begin fails++; $display("FAIL hold_valid_delay got %0d want 135", first); end
    tests++;
    if (nmac != 64) begin fails++; $display("FAIL hold_mac_pulses got %0d want 64", nmac); end
    tests++;
    if ({y, x} !== 6'd0) begin fails++; $display("FAIL hold_coef got (%0d,%0d) want (0,0)", x, y); end
    hold = 1'b0;
    do_abort();
  endtask

  task automatic test_back_pressure;
    int c = 1;
    logic [5:0] e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
    out_ready = 1'b1;
    pulse_start();
    while (c < 700 && !(out_valid && x == 3'd3 && y == 3'd0)) begin
      if (out_valid) begin
        tests++;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 6'h3f;
        if ({y, x} !== e) begin fails++; $display("FAIL bp_coef got %0d want %0d", {y, x}, e); end
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, y, x} !== {1'b1, 3'd0, 3'd3}) begin
        fails++; $display("FAIL bp_stable got valid=%b x=%0d y=%0d want 1 3 0", out_valid, x, y);
      end
    end
    tests++;
    e = exp_q.size() != 0 ? exp_q.pop_front() : 6'h3f;
    if ({y, x} !== e) begin fails++; $display("FAIL bp_held_coef got %0d want %0d", {y, x}, e); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, y, x} !== {1'b0, 3'd0, 3'd4}) begin
      fails++; $display("FAIL bp_advance got valid=%b x=%0d y=%0d want 0 4 0", out_valid, x, y);
    end
    do_abort();
  endtask

  task automatic test_abort;
    int c = 0;
    int ndone = 0;
    out_ready = 1'b1;
    pulse_start();
    while (c < 2000 && !(x == 3'd2 && y == 3'd1 && u == 3'd3 && rd_en)) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if ({y, x, u} !== {3'd1, 3'd2, 3'd3}) begin
      fails++; $display("FAIL abort_reach got x=%0d y=%0d u=%0d want 2 1 3", x, y, u);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({busy, done, acc_clr, rd_en, act_mac, out_valid, address, u, v, x, y} !== 24'd0) begin
      fails++; $display("FAIL abort_outputs got %h want 0", {busy, done, acc_clr, rd_en, act_mac, out_valid, address, u, v, x, y});
    end
    repeat (5) begin
      if (done) ndone++;
      @(negedge clk);
    end
    tests++;
    if (ndone != 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_with_abort busy got %b want 0", busy); end
    pulse_start();
    tests++;
    if ({busy, acc_clr, y, x} !== {1'b1, 1'b1, 6'd0}) begin
      fails++; $display("FAIL abort_restart got busy=%b clr=%b x=%0d y=%0d want 1 1 0 0", busy, acc_clr, x, y);
    end
    c = 1;
    while (c < 300 && !out_valid) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c != 130 || {y, x} !== 6'd0) begin
      fails++; $display("FAIL abort_restart_coef got cycle %0d (%0d,%0d) want 130 (0,0)", c, x, y);
    end
    do_abort();
  endtask

  task automatic test_async_reset;
    int c = 1;
    out_ready = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    #2 rst_in = 1'b1;
    #1;
    tests++;
    if ({busy, done, acc_clr, rd_en, act_mac, out_valid, address, u, v, x, y} !== 24'd0) begin
      fails++; $display("FAIL async_reset got %h want 0", {busy, done, acc_clr, rd_en, act_mac, out_valid, address, u, v, x, y});
    end
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    pulse_start();
    while (c < 300 && !out_valid) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c != 130 || {y, x} !== 6'd0) begin
      fails++; $display("FAIL reset_clean_block got cycle %0d (%0d,%0d) want 130 (0,0)", c, x, y);
    end
`ifdef DCT_SEQ_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
    repeat (2) @(negedge clk);
    hold = 1'b1;
    repeat (7) @(negedge clk);
    hold = 1'b0;
    tests++;
    if (stall_cnt !== 16'd7) begin fails++; $display("FAIL stall_count got %0d want 7", stall_cnt); end
    do_abort();
    tests++;
    if (stall_cnt !== 16'd7) begin fails++; $display("FAIL stall_idle_hold got %0d want 7", stall_cnt); end
`else
    do_abort();
`endif
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_small();
    test_hold();
    test_back_pressure();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dct_seq_ctrl.md
Name: dct_seq_ctrl

Overview:
- Parametrised sequencer for the block 2-D transform datapath. Block size is N x N, with N = 2**LOG2N.
- For each output coefficient (x,y), it clears the MAC accumulator, then steps through all N*N input samples (u,v). For each sample it drives the sample-memory address and the MAC enables.
- Each finished coefficient is presented with a valid/ready handshake.
- Sits between the frame/block controller (start/done) and the sample RAM plus MAC unit. Adds datapath stall, abort and back-pressure support.

Parameters:
- LOG2N, 3, log2 of block dimension. N = 2**LOG2N; legal values 1..4.
- AW, 2*LOG2N, sample-memory address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_in  in  1  asynchronous, active-high reset.
- start  in  1  begin one block; sampled only in IDLE.
- hold  in  1  datapath stall; freezes the inner loop while high.
- abort  in  1  synchronous abort; returns to IDLE.
- out_ready  in  1  consumer accepts the current coefficient.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last coefficient is accepted.
- acc_clr  out  1  one-cycle MAC accumulator clear.
- rd_en  out  1  sample-memory read enable.
- act_mac  out  1  MAC accumulate enable.
- address  out  AW  sample address = {u,v} (u is the MSBs).
- u, v  out  LOG2N each  current input-sample indices.
- x, y  out  LOG2N each  current output-coefficient indices.
- out_valid  out  1  coefficient for (x,y) is valid in the MAC.

Behaviour:
- All outputs are registered on posedge clk.
- Reset (rst_in=1, asynchronous): state=IDLE; every output 0; u,v,x,y,address all 0.
- States: IDLE, CLR, RD, MAC, RESULT.
- IDLE: outputs 0. start=1 -> CLR. x,y,u,v are zeroed on entry.
- CLR: acc_clr=1 for one cycle; u=v=0 -> RD.
- RD: rd_en=1, act_mac=0, address={u,v} -> MAC.
- MAC: rd_en=1, act_mac=1.
  - If (u,v) is not (N-1,N-1): advance v; when v wraps to 0, increment u; -> RD.
  - If (u,v) = (N-1,N-1): -> RESULT.
- RESULT: out_valid=1, held stable with x,y until out_ready=1. On the handshake:
  - if (x,y) = (N-1,N-1): -> IDLE and pulse done in the following cycle (the first IDLE cycle);
  - otherwise advance x (when x wraps to 0, increment y) -> CLR.
- Inner-loop cost: 2 cycles per sample. With no hold, out_valid rises 2+2*N*N cycles after the edge that samples start (130 for N=8).
- Full block with out_ready tied high: N*N*(2*N*N+2) cycles (8320 for N=8).
- hold=1 in RD or MAC:
  - state and all counters freeze;
  - act_mac is forced to 0, so no double accumulation;
  - rd_en is held at its state value.
  - When hold drops, the state resumes with no lost or repeated sample.
- hold is ignored in IDLE, CLR and RESULT.
- abort=1 in any state: next cycle IDLE with all outputs 0 and no done pulse. abort has priority over out_ready and hold.
- start while busy=1: ignored. start and abort together in IDLE: stay in IDLE.
- u,v,x,y wrap modulo N. address equals {u,v} in every cycle.

Optional Feature:
- DCT_SEQ_STALL_CNT_EN defined: adds output stall_cnt [15:0].
  - Counts cycles with hold=1 while in RD or MAC.
  - Saturates at 16'hFFFF.
  - Cleared on reset and when start is accepted.
  - Holds its value in IDLE.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package dct_seq_pkg:
  - state enum (IDLE, CLR, RD, MAC, RESULT);
  - default LOG2N;
  - localparam helpers N and AW.
- Sub-module dct_idx_cnt: a 2-D wrap counter, parameter LOG2N.
  - Inputs: clr, inc. Outputs: row, col, last.
  - col increments; on col wrap, row increments; last = both at N-1.
  - Instantiated twice: once for (u,v), once for (x,y).

Test Plan:
- LOG2N=3, start pulse, out_ready=1, no hold -> first out_valid exactly 130 cycles after the start-sampling edge; 64 coefficients at x,y in order (0,0),(1,0)..(7,7); done pulses once; 8320 cycles total.
- LOG2N=1, out_ready=1 -> address sequence 0,1,2,3 per coefficient; act_mac high 4 cycles per acc_clr pulse; 4 coefficients; done asserted.
- LOG2N=3, hold=1 for 5 cycles during MAC at (u,v)=(2,5) -> act_mac low throughout the hold; 64 act_mac pulses per coefficient; out_valid delayed by exactly 5 cycles.
- out_ready held low 10 cycles in RESULT at (x,y)=(3,0) -> out_valid, x, y stable for the whole wait; advance to (4,0) on the handshake.
- abort at (x,y)=(2,1) mid inner loop -> next cycle IDLE, all outputs 0, no done; a new start restarts at (0,0).
- rst_in asserted mid-block, asynchronously -> outputs 0 immediately; after release, start runs a clean block. With DCT_SEQ_STALL_CNT_EN, 7 hold cycles -> stall_cnt=7.
